slot_game_ctrl: RTL and testbench
=================================

Name: slot_game_ctrl

Overview:
- Game sequencer for the VGA slot-machine screen.
- Owns player credit and the bet, and the three reel symbol states that drive the Symbol rot_state inputs.
- Times spin start, the staggered reel stops and the win evaluation, then animates the payout into credit.
- Outputs feed the display: credit goes to deco_BDS, reels to the Symbol rot_state inputs, stop to the reel counter enable.

Parameters:
- START_CREDIT, 100, credit value after reset.
- MAX_CREDIT, 999, credit saturation ceiling (three displayed digits).
- SPIN_FRAMES, 90, frame ticks with all reels running before reel0 auto-stops.
- STOP_GAP, 30, frame ticks between successive auto-stops.
- STEP_FRAMES, 4, base symbol period in frame ticks. Reel k steps every STEP_FRAMES+k ticks.
- PAY_TRIPLE, 10, payout multiplier when all three reels match.
- PAY_PAIR, 2, payout multiplier when two adjacent reels match.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- btn_bet  in  1  synchronous level, active-high
- btn_spin  in  1  synchronous level, active-high
- btn_cashout  in  1  synchronous level, active-high
- credit  out  10  current credit, 0..MAX_CREDIT
- bet  out  2  current bet, 1..3
- reel0, reel1, reel2  out  2 each  centre-row symbol per reel
- reel_run  out  3  bit k high while reel k is spinning
- stop  out  1  high when ~|reel_run
- win  out  1  last spin paid more than 0
- payout  out  6  amount won by the last spin
- state_o  out  3  FSM state encoding

Behaviour:
- Reset values: credit=START_CREDIT, bet=1, reels=0, reel_run=0, stop=1, win=0, payout=0, state=IDLE. Reset takes effect asynchronously at any point, including mid-spin and mid-payout.
- Buttons:
  - Each button is registered; the block acts only on the rising edge (level high now, low on the previous cycle).
  - Holding a button produces exactly one event.
  - Debouncing is outside this block.
- IDLE:
  - A spin edge is accepted only when credit >= bet. On acceptance: credit -= bet, win=0, payout=0, reel_run=3'b111, step and frame counters cleared, next state RUN3.
  - A spin edge with credit < bet is ignored.
  - Otherwise a cashout edge sets credit=0.
  - Otherwise a bet edge cycles bet 1->2->3->1.
  - Priority when edges coincide: spin > cashout > bet. Lower-priority edges in the same cycle are dropped.
- Reel stepping:
  - On each frame_tick, each running reel k increments its step counter.
  - When the counter reaches STEP_FRAMES+k, the reel symbol increments mod 4 and the counter clears.
  - Stopped reels freeze their symbol.
- RUN3 / RUN2 / RUN1:
  - A frame counter counts frame_ticks in the current state.
  - The state is left on the tick that makes the count equal SPIN_FRAMES (RUN3) or STOP_GAP (RUN2, RUN1), or on a spin edge (early player stop).
  - On exit, the next reel in order (0, then 1, then 2) clears its reel_run bit and the frame counter clears. Order: RUN3 -> RUN2 -> RUN1 -> EVAL.
  - If a tick coincides with the exit, the step for that tick is applied first, then the reel freezes.
  - Bet and cashout edges are ignored outside IDLE.
- EVAL (1 cycle):
  - All three equal: payout = bet*PAY_TRIPLE.
  - Else reel0==reel1 or reel1==reel2: payout = bet*PAY_PAIR.
  - Else payout = 0.
  - win = (payout != 0). Next state is PAYOUT if payout != 0, else IDLE.
- PAYOUT:
  - An internal remaining counter is loaded with payout.
  - Each frame_tick adds 1 to credit and decrements remaining.
  - Exit to IDLE when remaining==0 or credit==MAX_CREDIT. Any unpaid remainder is discarded.
  - credit never exceeds MAX_CREDIT.
- All arithmetic is unsigned. Credit subtraction cannot underflow because of the IDLE credit check.

Decomposition:
- Package slot_pkg: state enum (IDLE, RUN3, RUN2, RUN1, EVAL, PAYOUT), SYM_W=2, CREDIT_W=10, PAY_W=6.
- Sub-module reel_stepper, instantiated three times with a PERIOD parameter.
  - Ports: clk, rst, clear, run, frame_tick, sym[1:0].
  - Contents: the symbol register and the step counter.

Test Plan:
- Reset -> credit=100, bet=1, reels=0,0,0, stop=1, state IDLE. Pulse btn_bet 3 times -> bet goes 2, 3, 1.
- SPIN_FRAMES=4, STOP_GAP=2, STEP_FRAMES=1: spin edge, then 8 frame_ticks with no further presses -> credit=99, reels stop at 0,3,2 after ticks 4, 6, 8, win=0, back in IDLE.
- From reset, spin edge, then three further spin edges before any frame_tick -> reels 0,0,0, payout=10, credit climbs 99->109 over 10 frame_ticks, win=1.
- START_CREDIT=995, same early-stop triple -> credit 994 climbs to 999 after 5 ticks, then IDLE (remaining 5 dropped).
- START_CREDIT=2, bet=3, spin edge -> ignored, IDLE, credit=2. Cashout edge -> credit=0. Bet and spin edges in the same cycle with credit=0 -> nothing happens.
- Assert rst during PAYOUT -> same cycle: credit=100, state IDLE, reel_run=0, win=0.

Source files
------------

// File: rtl/slot_game_ctrl_pkg.sv
// Shared types and widths for the slot-machine game sequencer.
package slot_pkg;

  localparam int SYM_W    = 2;
  localparam int CREDIT_W = 10;
  localparam int PAY_W    = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN3   = 3'd1,
    RUN2   = 3'd2,
    RUN1   = 3'd3,
    EVAL   = 3'd4,
    PAYOUT = 3'd5
  } state_t;

  // Bet cycles 1 -> 2 -> 3 -> 1.
  function automatic logic [1:0] next_bet(input logic [1:0] b);
    return (b == 2'd3) ? 2'd1 : b + 2'd1;
  endfunction

  // Reels stop in order 0, 1, 2; after the last stop the spin is evaluated.
  function automatic state_t next_run_state(input state_t s);
    case (s)
      RUN3:    return RUN2;
      RUN2:    return RUN1;
      default: return EVAL;
    endcase
  endfunction

endpackage

// File: rtl/slot_game_ctrl_if.sv
// Player/display bundle of the slot-machine sequencer: buttons and frame tick in, game state out.
interface slot_game_ctrl_if;
  import slot_pkg::*;

  // No valid/ready here: buttons are synchronous levels acted on at their rising
  // edge, frame_tick is a one-cycle pulse, and every output is a registered level.
  logic                frame_tick;
  logic                btn_bet;
  logic                btn_spin;
  logic                btn_cashout;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          bet;
  logic [SYM_W-1:0]    reel0;
  logic [SYM_W-1:0]    reel1;
  logic [SYM_W-1:0]    reel2;
  logic [2:0]          reel_run;
  logic                stop;
  logic                win;
  logic [PAY_W-1:0]    payout;
  logic [2:0]          state_o;

  modport master (
    output frame_tick, btn_bet, btn_spin, btn_cashout,
    input  credit, bet, reel0, reel1, reel2, reel_run, stop, win, payout, state_o
  );

  modport slave (
    input  frame_tick, btn_bet, btn_spin, btn_cashout,
    output credit, bet, reel0, reel1, reel2, reel_run, stop, win, payout, state_o
  );

endinterface

// File: rtl/slot_game_ctrl_reel_stepper.sv
// One reel: a symbol register advanced once every PERIOD frame ticks while running.
module reel_stepper
  import slot_pkg::*;
#(
  parameter int PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             frame_tick,
  output logic [SYM_W-1:0] sym
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // clear only restarts the period; the symbol carries over from the previous spin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sym <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && frame_tick) begin
      if (cnt == LAST) begin
        cnt <= '0;
        sym <= sym + SYM_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/slot_game_ctrl.sv
// Slot-machine game sequencer: credit/bet, spin timing, staggered reel stops, win evaluation, payout.
module slot_game_ctrl
  import slot_pkg::*;
#(
  parameter int START_CREDIT = 100,
  parameter int MAX_CREDIT   = 999,
  parameter int SPIN_FRAMES  = 90,
  parameter int STOP_GAP     = 30,
  parameter int STEP_FRAMES  = 4,
  parameter int PAY_TRIPLE   = 10,
  parameter int PAY_PAIR     = 2
) (
  input logic        clk,
  input logic        rst,
  slot_game_ctrl_if.slave bus
);

  localparam int FC_MAX = (SPIN_FRAMES > STOP_GAP) ? SPIN_FRAMES : STOP_GAP;
  localparam int FC_W   = $clog2(FC_MAX + 1);

  localparam logic [FC_W-1:0]     SPIN_LIM    = FC_W'(SPIN_FRAMES);
  localparam logic [FC_W-1:0]     GAP_LIM     = FC_W'(STOP_GAP);
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(START_CREDIT);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);
  localparam logic [PAY_W-1:0]    TRIPLE_K    = PAY_W'(PAY_TRIPLE);
  localparam logic [PAY_W-1:0]    PAIR_K      = PAY_W'(PAY_PAIR);
  localparam logic [PAY_W-1:0]    PAY_ONE     = PAY_W'(1);

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit, credit_d;
  logic [1:0]          bet, bet_d;
  logic [2:0]          run, run_d;
  logic                win, win_d;
  logic [PAY_W-1:0]    payout, payout_d;
  logic [PAY_W-1:0]    remain, remain_d;
  logic [FC_W-1:0]     fcnt, fcnt_d;
  logic [FC_W-1:0]     fcnt_inc;
  logic [FC_W-1:0]     stage_lim;
  logic [PAY_W-1:0]    pay;
  logic                clear_steps;
  logic [SYM_W-1:0]    reel [3];

  // Button edge detect, bit order {cashout, spin, bet}.
  logic [2:0] btn_r, btn_prev, btn_edge;
  logic       bet_edge, spin_edge, cash_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_r    <= '0;
      btn_prev <= '0;
    end else begin
      btn_r    <= {bus.btn_cashout, bus.btn_spin, bus.btn_bet};
      btn_prev <= btn_r;
    end
  end

  assign btn_edge  = btn_r & ~btn_prev;
  assign bet_edge  = btn_edge[0];
  assign spin_edge = btn_edge[1];
  assign cash_edge = btn_edge[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      credit <= CREDIT_INIT;
      bet    <= 2'd1;
      run    <= '0;
      win    <= 1'b0;
      payout <= '0;
      remain <= '0;
      fcnt   <= '0;
    end else begin
      state  <= state_d;
      credit <= credit_d;
      bet    <= bet_d;
      run    <= run_d;
      win    <= win_d;
      payout <= payout_d;
      remain <= remain_d;
      fcnt   <= fcnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    credit_d    = credit;
    bet_d       = bet;
    run_d       = run;
    win_d       = win;
    payout_d    = payout;
    remain_d    = remain;
    fcnt_d      = fcnt;
    clear_steps = 1'b0;
    pay         = '0;
    fcnt_inc    = fcnt + FC_W'(1);
    stage_lim   = (state == RUN3) ? SPIN_LIM : GAP_LIM;

    case (state)
      IDLE: begin
        // A rejected spin still swallows any bet/cashout edge of the same cycle.
        if (spin_edge) begin
          if (credit >= CREDIT_W'(bet)) begin
            credit_d    = credit - CREDIT_W'(bet);
            win_d       = 1'b0;
            payout_d    = '0;
            run_d       = 3'b111;
            fcnt_d      = '0;
            clear_steps = 1'b1;
            state_d     = RUN3;
          end
        end else if (cash_edge) begin
          credit_d = '0;
        end else if (bet_edge) begin
          bet_d = next_bet(bet);
        end
      end

      RUN3, RUN2, RUN1: begin
        if (bus.frame_tick) fcnt_d = fcnt_inc;
        // A tick on the exit cycle still steps the reel: the stepper sees run high this cycle.
        if (spin_edge || (bus.frame_tick && fcnt_inc == stage_lim)) begin
          fcnt_d  = '0;
          run_d   = {run[1:0], 1'b0};
          state_d = next_run_state(state);
        end
      end

      EVAL: begin
        if (reel[0] == reel[1] && reel[1] == reel[2]) begin
          pay = PAY_W'(bet) * TRIPLE_K;
        end else if (reel[0] == reel[1] || reel[1] == reel[2]) begin
          pay = PAY_W'(bet) * PAIR_K;
        end
        payout_d = pay;
        remain_d = pay;
        win_d    = (pay != '0);
        state_d  = (pay != '0) ? PAYOUT : IDLE;
      end

      PAYOUT: begin
        // Reaching the ceiling ends the payout; the unpaid remainder is dropped.
        if (remain == '0 || credit >= CREDIT_MAX) begin
          state_d = IDLE;
        end else if (bus.frame_tick) begin
          credit_d = credit + CREDIT_ONE;
          remain_d = remain - PAY_ONE;
          if (remain_d == '0 || credit_d == CREDIT_MAX) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < 3; k++) begin : g_reel
    reel_stepper #(
      .PERIOD(STEP_FRAMES + k)
    ) u_reel (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_steps),
      .run       (run[k]),
      .frame_tick(bus.frame_tick),
      .sym       (reel[k])
    );
  end

  assign bus.credit   = credit;
  assign bus.bet      = bet;
  assign bus.reel0    = reel[0];
  assign bus.reel1    = reel[1];
  assign bus.reel2    = reel[2];
  assign bus.reel_run = run;
  assign bus.stop     = ~|run;
  assign bus.win      = win;
  assign bus.payout   = payout;
  assign bus.state_o  = state;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Bench for slot_game_ctrl: three instances (start credit 100, 995, 2) checked against an arithmetic game model.
module tb_slot_game_ctrl;

  localparam int SPIN_F = 4;
  localparam int GAP_F  = 2;
  localparam int STEP_F = 1;
  localparam int MAX_C  = 999;
  localparam int P_TRI  = 10;
  localparam int P_PAIR = 2;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PAYOUT = 3'd5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  int start_c [3];
  int m_credit [3];
  int m_bet [3];
  int m_sym [3][3];

  integer o_credit, o_bet, o_run, o_stop, o_win, o_payout, o_state;
  integer o_reel [3];

  slot_game_ctrl_if bus0 ();
  slot_game_ctrl_if bus1 ();
  slot_game_ctrl_if bus2 ();

  slot_game_ctrl #(.START_CREDIT(100), .SPIN_FRAMES(SPIN_F), .STOP_GAP(GAP_F), .STEP_FRAMES(STEP_F))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  slot_game_ctrl #(.START_CREDIT(995), .SPIN_FRAMES(SPIN_F), .STOP_GAP(GAP_F), .STEP_FRAMES(STEP_F))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  slot_game_ctrl #(.START_CREDIT(2), .SPIN_FRAMES(SPIN_F), .STOP_GAP(GAP_F), .STEP_FRAMES(STEP_F))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive(input int d, input logic t, input logic s, input logic b, input logic c);
    case (d)
      0: begin bus0.frame_tick = t; bus0.btn_spin = s; bus0.btn_bet = b; bus0.btn_cashout = c; end
      1: begin bus1.frame_tick = t; bus1.btn_spin = s; bus1.btn_bet = b; bus1.btn_cashout = c; end
      default: begin bus2.frame_tick = t; bus2.btn_spin = s; bus2.btn_bet = b; bus2.btn_cashout = c; end
    endcase
  endtask

  task automatic pulse(input int d, input logic t, input logic s, input logic b, input logic c);
    drive(d, t, s, b, c);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic sample(input int d);
    case (d)
      0: begin
        o_credit = 32'(bus0.credit); o_bet = 32'(bus0.bet); o_run = 32'(bus0.reel_run);
        o_stop = 32'(bus0.stop); o_win = 32'(bus0.win); o_payout = 32'(bus0.payout); o_state = 32'(bus0.state_o);
        o_reel[0] = 32'(bus0.reel0); o_reel[1] = 32'(bus0.reel1); o_reel[2] = 32'(bus0.reel2);
      end
      1: begin
        o_credit = 32'(bus1.credit); o_bet = 32'(bus1.bet); o_run = 32'(bus1.reel_run);
        o_stop = 32'(bus1.stop); o_win = 32'(bus1.win); o_payout = 32'(bus1.payout); o_state = 32'(bus1.state_o);
        o_reel[0] = 32'(bus1.reel0); o_reel[1] = 32'(bus1.reel1); o_reel[2] = 32'(bus1.reel2);
      end
      default: begin
        o_credit = 32'(bus2.credit); o_bet = 32'(bus2.bet); o_run = 32'(bus2.reel_run);
        o_stop = 32'(bus2.stop); o_win = 32'(bus2.win); o_payout = 32'(bus2.payout); o_state = 32'(bus2.state_o);
        o_reel[0] = 32'(bus2.reel0); o_reel[1] = 32'(bus2.reel1); o_reel[2] = 32'(bus2.reel2);
      end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_credit[d] = start_c[d];
      m_bet[d]    = 1;
      for (int k = 0; k < 3; k++) m_sym[d][k] = 0;
    end
  endtask

  // One full spin; n[k] = ticks spent in stage k before a player stop (n >= limit means auto-stop).
  task automatic run_spin(input int d, input int n0, input int n1, input int n2);
    int n [3];
    int lim, cnt, tot, pay, exp_ticks, ticks, room;
    n[0] = n0; n[1] = n1; n[2] = n2;
    pulse(d, 1'b0, 1'b1, 1'b0, 1'b0);
    sample(d);
    if (m_credit[d] < m_bet[d]) begin
      total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL spin_ignored_state d%0d: got %0d want %0d", d, o_state, ST_IDLE); end
      total++; if (o_credit !== m_credit[d]) begin bad++; $display("FAIL spin_ignored_credit d%0d: got %0d want %0d", d, o_credit, m_credit[d]); end
      total++; if (o_run !== 0) begin bad++; $display("FAIL spin_ignored_run d%0d: got %0d want 0", d, o_run); end
    end else begin
      m_credit[d] -= m_bet[d];
      total++; if (o_credit !== m_credit[d]) begin bad++; $display("FAIL spin_debit d%0d: got %0d want %0d", d, o_credit, m_credit[d]); end
      total++; if (o_run !== 7 || o_stop !== 0) begin bad++; $display("FAIL spin_start_run d%0d: got run=%0d stop=%0d want run=7 stop=0", d, o_run, o_stop); end
      total++; if (o_win !== 0 || o_payout !== 0) begin bad++; $display("FAIL spin_start_clear d%0d: got win=%0d payout=%0d want 0 0", d, o_win, o_payout); end
      tot = 0;
      for (int k = 0; k < 3; k++) begin
        lim = (k == 0) ? SPIN_F : GAP_F;
        cnt = (n[k] < lim) ? n[k] : lim;
        repeat (cnt) pulse(d, 1'b1, 1'b0, 1'b0, 1'b0);
        if (n[k] < lim) pulse(d, 1'b0, 1'b1, 1'b0, 1'b0);
        tot += cnt;
        m_sym[d][k] = (m_sym[d][k] + tot / (STEP_F + k)) % 4;
        sample(d);
        total++; if (o_run !== ((7 << (k + 1)) & 7)) begin bad++; $display("FAIL reel_run_stage%0d d%0d: got %0d want %0d", k, d, o_run, (7 << (k + 1)) & 7); end
        total++; if (o_reel[k] !== m_sym[d][k]) begin bad++; $display("FAIL reel%0d_stop d%0d: got %0d want %0d", k, d, o_reel[k], m_sym[d][k]); end
      end
      if (m_sym[d][0] == m_sym[d][1] && m_sym[d][1] == m_sym[d][2]) pay = m_bet[d] * P_TRI;
      else if (m_sym[d][0] == m_sym[d][1] || m_sym[d][1] == m_sym[d][2]) pay = m_bet[d] * P_PAIR;
      else pay = 0;
      total++; if (o_payout !== pay) begin bad++; $display("FAIL payout d%0d: got %0d want %0d", d, o_payout, pay); end
      total++; if (o_win !== (pay != 0 ? 1 : 0)) begin bad++; $display("FAIL win d%0d: got %0d want %0d", d, o_win, pay != 0); end
      total++; if (o_stop !== 1) begin bad++; $display("FAIL stop d%0d: got %0d want 1", d, o_stop); end
      room      = MAX_C - m_credit[d];
      exp_ticks = (pay < room) ? pay : room;
      ticks = 0;
      while (o_state !== ST_IDLE && ticks < 64) begin
        pulse(d, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks++;
        sample(d);
      end
      m_credit[d] += exp_ticks;
      total++; if (ticks !== exp_ticks) begin bad++; $display("FAIL payout_ticks d%0d: got %0d want %0d", d, ticks, exp_ticks); end
      total++; if (o_credit !== m_credit[d]) begin bad++; $display("FAIL credit_after d%0d: got %0d want %0d", d, o_credit, m_credit[d]); end
      for (int k = 0; k < 3; k++) begin
        total++; if (o_reel[k] !== m_sym[d][k]) begin bad++; $display("FAIL reel%0d_final d%0d: got %0d want %0d", k, d, o_reel[k], m_sym[d][k]); end
      end
    end
  endtask

  // Scenario tasks
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      sample(d);
      total++; if (o_credit !== start_c[d]) begin bad++; $display("FAIL reset_credit d%0d: got %0d want %0d", d, o_credit, start_c[d]); end
      total++; if (o_bet !== 1) begin bad++; $display("FAIL reset_bet d%0d: got %0d want 1", d, o_bet); end
      total++; if (o_reel[0] !== 0 || o_reel[1] !== 0 || o_reel[2] !== 0) begin bad++; $display("FAIL reset_reels d%0d: got %0d %0d %0d want 0 0 0", d, o_reel[0], o_reel[1], o_reel[2]); end
      total++; if (o_run !== 0 || o_stop !== 1) begin bad++; $display("FAIL reset_run d%0d: got run=%0d stop=%0d want 0 1", d, o_run, o_stop); end
      total++; if (o_win !== 0 || o_payout !== 0) begin bad++; $display("FAIL reset_win d%0d: got %0d %0d want 0 0", d, o_win, o_payout); end
      total++; if (o_state !== ST_IDLE) begin bad++; $display("FAIL reset_state d%0d: got %0d want %0d", d, o_state, ST_IDLE); end
    end
  endtask

  task automatic test_bet_cycle();
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1'b0, 1'b0, 1'b1, 1'b0);
      m_bet[0] = m_bet[0] % 3 + 1;
      sample(0);
      total++; if (o_bet !== m_bet[0]) begin bad++; $display("FAIL bet_cycle%0d: got %0d want %0d", i, o_bet, m_bet[0]); end
    end
  endtask

  task automatic test_hold();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    m_bet[0] = m_bet[0] % 3 + 1;
    sample(0);
    total++; if (o_bet !== m_bet[0]) begin bad++; $display("FAIL bet_hold: got %0d want %0d", o_bet, m_bet[0]); end
  endtask

  task automatic test_reject();
    pulse(2, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(2, 1'b0, 1'b0, 1'b1, 1'b0);
    m_bet[2] = 3;
    run_spin(2, 0, 0, 0);
    pulse(2, 1'b0, 1'b0, 1'b0, 1'b1);
    m_credit[2] = 0;
    sample(2);
    total++; if (o_credit !== 0) begin bad++; $display("FAIL cashout_credit: got %0d want 0", o_credit); end
    pulse(2, 1'b0, 1'b1, 1'b1, 1'b0);
    sample(2);
    total++; if (o_bet !== 3 || o_credit !== 0 || o_state !== ST_IDLE) begin bad++; $display("FAIL spin_bet_drop: got bet=%0d credit=%0d state=%0d want 3 0 %0d", o_bet, o_credit, o_state, ST_IDLE); end
    pulse(2, 1'b0, 1'b0, 1'b1, 1'b1);
    sample(2);
    total++; if (o_bet !== 3 || o_credit !== 0) begin bad++; $display("FAIL cash_bet_drop: got bet=%0d credit=%0d want 3 0", o_bet, o_credit); end
  endtask

  task automatic test_random();
    int presses;
    for (int it = 0; it < 8; it++) begin
      presses = $urandom_range(0, 2);
      for (int p = 0; p < presses; p++) begin
        pulse(0, 1'b0, 1'b0, 1'b1, 1'b0);
        m_bet[0] = m_bet[0] % 3 + 1;
      end
      sample(0);
      total++; if (o_bet !== m_bet[0]) begin bad++; $display("FAIL rand_bet it%0d: got %0d want %0d", it, o_bet, m_bet[0]); end
      run_spin(0, $urandom_range(0, SPIN_F), $urandom_range(0, GAP_F), $urandom_range(0, GAP_F));
    end
  endtask

  task automatic test_reset_payout();
    pulse(1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) pulse(1, 1'b0, 1'b1, 1'b0, 1'b0);
    sample(1);
    total++; if (o_state !== ST_PAYOUT) begin bad++; $display("FAIL pre_reset_state: got %0d want %0d", o_state, ST_PAYOUT); end
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d);
      total++; if (o_credit !== start_c[d] || o_state !== ST_IDLE) begin bad++; $display("FAIL async_reset d%0d: got credit=%0d state=%0d want %0d %0d", d, o_credit, o_state, start_c[d], ST_IDLE); end
      total++; if (o_run !== 0 || o_win !== 0) begin bad++; $display("FAIL async_reset_run d%0d: got run=%0d win=%0d want 0 0", d, o_run, o_win); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    start_c[0] = 100; start_c[1] = 995; start_c[2] = 2;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    test_reset();
    test_bet_cycle();
    run_spin(0, 0, 0, 0);
    run_spin(0, SPIN_F, GAP_F, GAP_F);
    test_hold();
    run_spin(1, 0, 0, 0);
    test_reject();
    test_random();
    test_reset_payout();
    test_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
